// File: rtl/fbuf_scanout_if.sv
// Framebuffer read port plus video output bundle between scanout and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the raster free-runs and every sink must take each pixel.
interface fbuf_scanout_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) ();
  logic                  fbuf_en_rd;
  logic [ADDR_WIDTH-1:0] fbuf_addr_rd;
  logic [DATA_WIDTH-1:0] fbuf_data_rd;
  logic                  vid_hsync;
  logic                  vid_vsync;
  logic                  vid_de;
  logic [23:0]           vid_rgb;
  logic                  frame_start;

  // scanout side: drives the read port and the video stream
  modport master (
    output fbuf_en_rd, fbuf_addr_rd,
    input  fbuf_data_rd,
    output vid_hsync, vid_vsync, vid_de, vid_rgb, frame_start
  );

  // BRAM / encoder side
  modport slave (
    input  fbuf_en_rd, fbuf_addr_rd,
    output fbuf_data_rd,
    input  vid_hsync, vid_vsync, vid_de, vid_rgb, frame_start
  );
endinterface

// File: rtl/fbuf_scanout.sv
// Raster scanout: reads RGB332 pixels from framebuffer BRAM, emits 24-bit video with syncs.
// Latency: BRAM_LATENCY+2 clocks from raster counter to vid_* outputs.
// Backpressure: none; enable=0 or rst clears everything and restarts from pixel (0,0).
module fbuf_scanout #(
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int BRAM_LATENCY    = 2,
  parameter bit SYNC_POL        = 1'b0
) (
  input logic            clk,
  input logic            rst,
  input logic            enable,
  fbuf_scanout_if.master bus
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW         = $clog2(H_TOTAL + 1);
  localparam int VW         = $clog2(V_TOTAL + 1);
  // sideband delay: one stage beside the address register plus one per BRAM clock
  localparam int PIPE_DEPTH = BRAM_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic origin;
  } side_t;

  logic                       clear;
  logic [HW-1:0]              h_cnt;
  logic [VW-1:0]              v_cnt;
  side_t                      s0;
  side_t                      pipe [PIPE_DEPTH];
  side_t                      tail;
  logic                       en_rd_q;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q;
  logic [FBUF_DATA_WIDTH-1:0] pix;
  logic                       de_q;
  logic [23:0]                rgb_q;
  logic                       hsync_q;
  logic                       vsync_q;
  logic                       fs_q;

  // RGB332 -> RGB888 by bit replication so full-scale maps to 8'hFF
  function automatic logic [23:0] rgb332_to_888(input logic [FBUF_DATA_WIDTH-1:0] p);
    return {p[7:5], p[7:5], p[7:6],
            p[4:2], p[4:2], p[4:3],
            {4{p[1:0]}}};
  endfunction

  // reset and disable behave identically: everything returns to the origin
  assign clear = rst | ~enable;
  assign pix   = bus.fbuf_data_rd;
  assign tail  = pipe[PIPE_DEPTH-1];

  // raster counters; held at (0,0) while cleared so the first enabled cycle is the origin
  always_ff @(posedge clk) begin
    if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // stage-0 decode of the current raster position
  always_comb begin
    s0        = '0;
    s0.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    s0.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    s0.origin = (h_cnt == '0) && (v_cnt == '0);
  end

  // read address: running pixel counter, restarted at the origin, frozen during blanking
  always_ff @(posedge clk) begin
    if (clear) begin
      en_rd_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      en_rd_q <= s0.active;
      if (s0.origin) begin
        addr_q <= '0;
      end else if (s0.active) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // sideband shift pipeline keeps syncs/de/frame marker aligned with the returning pixel
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // output register; BRAM data outside the active window is discarded
  always_ff @(posedge clk) begin
    if (clear) begin
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      de_q    <= tail.active;
      rgb_q   <= tail.active ? rgb332_to_888(pix) : 24'h0;
      hsync_q <= tail.hs ? SYNC_POL : ~SYNC_POL;
      vsync_q <= tail.vs ? SYNC_POL : ~SYNC_POL;
      fs_q    <= tail.origin;
    end
  end

  assign bus.fbuf_en_rd   = en_rd_q;
  assign bus.fbuf_addr_rd = addr_q;
  assign bus.vid_de       = de_q;
  assign bus.vid_rgb      = rgb_q;
  assign bus.vid_hsync    = hsync_q;
  assign bus.vid_vsync    = vsync_q;
  assign bus.frame_start  = fs_q;

endmodule
